// File: rtl/hevc_interp_pkg.sv
// Shared constants for the HEVC luma interpolator: phase encodings,
// the 8-tap coefficient table, rounding constants and the sum width.
package hevc_interp_pkg;

  typedef enum logic [1:0] {
    PH_FULL = 2'd0,
    PH_Q1   = 2'd1,
    PH_HALF = 2'd2,
    PH_Q3   = 2'd3
  } phase_e;

  localparam int NUM_TAPS     = 8;
  localparam int FILTER_SHIFT = 6;
  localparam int ROUND_OFS    = 32;

  // Reference coefficients, tap 0 = oldest pixel. The datapath realises
  // these with shift-add terms; this table is the readable source of truth.
  localparam int LUMA_COEF [4][NUM_TAPS] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  // Signed sum width: worst-case positive gain is 88 and negative is 24,
  // both of which fit in 8 extra bits over the pixel.
  function automatic int sum_width(input int bit_depth);
    return bit_depth + 8;
  endfunction

endpackage

// File: rtl/hevc_luma_interp_stream_if.sv
// Pixel-in / sample-out stream bundle for the luma interpolator.
interface hevc_luma_interp_stream_if #(
  parameter int BIT_DEPTH = 8,
  parameter int TAG_W     = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_DEPTH-1:0] in_pixel;
  logic                 in_sol;
  logic                 in_eol;
  logic [1:0]           in_phase;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_DEPTH-1:0] out_pixel;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_eol;
  logic                 short_line_err;

  modport master (
    output in_valid, in_pixel, in_sol, in_eol, in_phase, in_tag, out_ready,
    input  in_ready, out_valid, out_pixel, out_tag, out_eol, short_line_err
  );

  modport slave (
    input  in_valid, in_pixel, in_sol, in_eol, in_phase, in_tag, out_ready,
    output in_ready, out_valid, out_pixel, out_tag, out_eol, short_line_err
  );
endinterface

// File: rtl/hevc_luma_tap_sum.sv
// Combinational 8-tap luma filter sum, shift-add only, for one phase.
// Full-pel returns 0; the caller bypasses the arithmetic for that phase.
module hevc_luma_tap_sum
  import hevc_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int SW        = sum_width(BIT_DEPTH)
) (
  input  logic [7:0][BIT_DEPTH-1:0] win,
  input  phase_e                    phase,
  output logic signed [SW-1:0]      sum
);
  typedef logic signed [SW-1:0] s_t;

  s_t x [NUM_TAPS];

  function automatic s_t m4 (input s_t a); return a <<< 2;                          endfunction
  function automatic s_t m5 (input s_t a); return (a <<< 2) + a;                    endfunction
  function automatic s_t m10(input s_t a); return (a <<< 3) + (a <<< 1);            endfunction
  function automatic s_t m11(input s_t a); return (a <<< 3) + (a <<< 1) + a;        endfunction
  function automatic s_t m17(input s_t a); return (a <<< 4) + a;                    endfunction
  function automatic s_t m40(input s_t a); return (a <<< 5) + (a <<< 3);            endfunction
  function automatic s_t m58(input s_t a); return (a <<< 6) - (a <<< 2) - (a <<< 1); endfunction

  // Zero-extend each unsigned pixel into the signed sum domain.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) x[k] = s_t'({8'd0, win[k]});
  end

  // Per-phase shift-add tree; intermediate wrap is harmless since the final sum fits.
  always_comb begin
    sum = '0;
    case (phase)
      PH_Q1:   sum = -x[0] + m4(x[1]) - m10(x[2]) + m58(x[3]) + m17(x[4]) - m5(x[5]) + x[6];
      PH_HALF: sum = -x[0] + m4(x[1]) - m11(x[2]) + m40(x[3]) + m40(x[4]) - m11(x[5]) + m4(x[6]) - x[7];
      PH_Q3:   sum =  x[1] - m5(x[2]) + m17(x[3]) + m58(x[4]) - m10(x[5]) + m4(x[6]) - x[7];
      default: sum = '0;
    endcase
  end

endmodule

// File: rtl/hevc_luma_interp_stream.sv
// Streaming HEVC 8-tap luma interpolator. S1 = sliding window + metadata,
// S2 = filter sum, S3 = rounded/clipped output register. Every stage moves
// only when the output register is free or being drained.
module hevc_luma_interp_stream
  import hevc_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int TAG_W     = 8
) (
  input logic                      clock,
  input logic                      reset_L,
  hevc_luma_interp_stream_if.slave io
);
  localparam int                   SW       = sum_width(BIT_DEPTH);
  localparam int                   STAGES   = 3;
  localparam logic [3:0]           FULL_CNT = 4'd8;
  localparam logic signed [SW-1:0] ROUND_S  = SW'(ROUND_OFS);
  localparam logic signed [SW-1:0] PIX_MAX  = SW'((1 << BIT_DEPTH) - 1);

  // S1: window and line state
  logic [7:0][BIT_DEPTH-1:0] win_d, win_q;
  logic [3:0]                fill_d, fill_q, fill_nxt;
  phase_e                    phase_d, phase_q;
  logic [TAG_W-1:0]          s1_tag_d, s1_tag_q;
  logic                      s1_eol_d, s1_eol_q;
  // S2: sum plus what the full-pel bypass needs
  logic signed [SW-1:0]      s2_sum_d, s2_sum_q;
  logic                      s2_full_d, s2_full_q;
  logic [BIT_DEPTH-1:0]      s2_w3_d, s2_w3_q;
  logic [TAG_W-1:0]          s2_tag_d, s2_tag_q;
  logic                      s2_eol_d, s2_eol_q;
  // S3: output register
  logic [BIT_DEPTH-1:0]      out_pixel_d, out_pixel_q;
  logic [TAG_W-1:0]          out_tag_d, out_tag_q;
  logic                      out_eol_d, out_eol_q;
  logic                      err_d, err_q;
  // vld_pipe_q[s] marks a real sample sitting in stage s
  logic [STAGES:1]           vld_pipe_d, vld_pipe_q;

  logic signed [SW-1:0]      tap_sum, rnd;
  logic [BIT_DEPTH-1:0]      clip_px;
  logic                      advance, accept;

  assign advance           = !vld_pipe_q[STAGES] || io.out_ready;
  assign accept            = io.in_valid && advance;
  assign io.in_ready       = advance;
  assign io.out_valid      = vld_pipe_q[STAGES];
  assign io.out_pixel      = out_pixel_q;
  assign io.out_tag        = out_tag_q;
  assign io.out_eol        = out_eol_q;
  assign io.short_line_err = err_q;

  hevc_luma_tap_sum #(.BIT_DEPTH(BIT_DEPTH), .SW(SW)) u_tap (
    .win   (win_q),
    .phase (phase_q),
    .sum   (tap_sum)
  );

  // Round, shift and two-sided clip of the S2 sum; full-pel passes w[3] through.
  always_comb begin
    rnd = (s2_sum_q + ROUND_S) >>> FILTER_SHIFT;
    if (s2_full_q)         clip_px = s2_w3_q;
    else if (rnd[SW-1])    clip_px = '0;
    else if (rnd > PIX_MAX) clip_px = '1;
    else                   clip_px = rnd[BIT_DEPTH-1:0];
  end

  // Next-state for window, fill count, line errors and the three stages.
  always_comb begin
    win_d       = win_q;
    fill_d      = fill_q;
    fill_nxt    = fill_q;
    phase_d     = phase_q;
    s1_tag_d    = s1_tag_q;
    s1_eol_d    = s1_eol_q;
    s2_sum_d    = s2_sum_q;
    s2_full_d   = s2_full_q;
    s2_w3_d     = s2_w3_q;
    s2_tag_d    = s2_tag_q;
    s2_eol_d    = s2_eol_q;
    out_pixel_d = out_pixel_q;
    out_tag_d   = out_tag_q;
    out_eol_d   = out_eol_q;
    err_d       = err_q;
    vld_pipe_d  = vld_pipe_q;
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], 1'b0};
      if (accept) begin
        win_d = {io.in_pixel, win_q[7:1]};
        // sol restarts the window; beats outside a line (fill 0) are dropped
        if (io.in_sol) begin
          fill_nxt = 4'd1;
          phase_d  = phase_e'(io.in_phase);
        end else if (fill_q == 4'd0) begin
          fill_nxt = 4'd0;
        end else if (fill_q != FULL_CNT) begin
          fill_nxt = fill_q + 4'd1;
        end
        vld_pipe_d[1] = (fill_nxt == FULL_CNT);
        s1_tag_d      = io.in_tag;
        s1_eol_d      = io.in_eol;
        if (io.in_eol) begin
          if (fill_nxt != 4'd0 && fill_nxt != FULL_CNT) err_d = 1'b1;
          fill_d = 4'd0;
        end else begin
          fill_d = fill_nxt;
        end
      end
      s2_sum_d  = tap_sum;
      s2_full_d = (phase_q == PH_FULL);
      s2_w3_d   = win_q[3];
      s2_tag_d  = s1_tag_q;
      s2_eol_d  = s1_eol_q;
      if (vld_pipe_q[2]) begin
        out_pixel_d = clip_px;
        out_tag_d   = s2_tag_q;
        out_eol_d   = s2_eol_q;
      end
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      win_q       <= '0;
      fill_q      <= '0;
      phase_q     <= PH_FULL;
      s1_tag_q    <= '0;
      s1_eol_q    <= 1'b0;
      s2_sum_q    <= '0;
      s2_full_q   <= 1'b0;
      s2_w3_q     <= '0;
      s2_tag_q    <= '0;
      s2_eol_q    <= 1'b0;
      out_pixel_q <= '0;
      out_tag_q   <= '0;
      out_eol_q   <= 1'b0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      win_q       <= win_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      s1_tag_q    <= s1_tag_d;
      s1_eol_q    <= s1_eol_d;
      s2_sum_q    <= s2_sum_d;
      s2_full_q   <= s2_full_d;
      s2_w3_q     <= s2_w3_d;
      s2_tag_q    <= s2_tag_d;
      s2_eol_q    <= s2_eol_d;
      out_pixel_q <= out_pixel_d;
      out_tag_q   <= out_tag_d;
      out_eol_q   <= out_eol_d;
      err_q       <= err_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

endmodule

// File: tb/tb_hevc_luma_interp_stream.sv
// Bench for hevc_luma_interp_stream: an 8-bit and a 10-bit instance run in
// lockstep (10-bit pixels are the 8-bit ones times 4), each checked against
// a beat-level reference model through a scoreboard queue.
module tb_hevc_luma_interp_stream;

  typedef struct { int px; int tag; int eol; } exp_t;
  typedef struct { string name; int ph; logic [63:0] px; int e8; int e10; } vec_t;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  hevc_luma_interp_stream_if #(.BIT_DEPTH(8),  .TAG_W(8)) if8 ();
  hevc_luma_interp_stream_if #(.BIT_DEPTH(10), .TAG_W(8)) if10 ();

  assign if10.in_valid  = if8.in_valid;
  assign if10.in_pixel  = {if8.in_pixel, 2'b00};
  assign if10.in_sol    = if8.in_sol;
  assign if10.in_eol    = if8.in_eol;
  assign if10.in_phase  = if8.in_phase;
  assign if10.in_tag    = if8.in_tag;
  assign if10.out_ready = if8.out_ready;

  hevc_luma_interp_stream #(.BIT_DEPTH(8),  .TAG_W(8)) u_dut8  (.clock(clock), .reset_L(reset_L), .io(if8));
  hevc_luma_interp_stream #(.BIT_DEPTH(10), .TAG_W(8)) u_dut10 (.clock(clock), .reset_L(reset_L), .io(if10));

  int   total = 0, bad = 0;
  exp_t q8[$], q10[$];
  exp_t e8, e10;
  int   popcyc[$];
  int   n8 = 0, n10 = 0, last8 = 0, last10 = 0, last_eol8 = 0;
  int   mw[8];
  int   mfill = 0, mphase = 0, merr = 0;
  int   tagc = 0, last_acc_cyc = 0;
  bit   bp_en = 1'b0;
  bit   hold_v = 1'b0;
  int   hold_px = 0, hold_tag = 0, hold_eol = 0;
  int   coef [4][8] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    total++;
    bad++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [63:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic int model_px(input int ph, input int scale, input int bd);
    int s  = 0;
    int mx = (1 << bd) - 1;
    int r;
    for (int k = 0; k < 8; k++) s += coef[ph][k] * mw[k] * scale;
    r = (s + 32) >>> 6;
    if (r < 0) r = 0;
    else if (r > mx) r = mx;
    return r;
  endfunction

  task automatic model_beat(input int pix, input bit sol, input bit eol, input int ph, input int tag);
    exp_t e;
    for (int k = 0; k < 7; k++) mw[k] = mw[k+1];
    mw[7] = pix;
    if (sol) begin
      mfill  = 1;
      mphase = ph;
    end else if (mfill != 0 && mfill < 8) begin
      mfill++;
    end
    if (mfill == 8) begin
      e.tag = tag & 255;
      e.eol = eol;
      e.px  = model_px(mphase, 1, 8);
      q8.push_back(e);
      e.px  = model_px(mphase, 4, 10);
      q10.push_back(e);
    end
    if (eol) begin
      if (mfill != 0 && mfill != 8) merr = 1;
      mfill = 0;
    end
  endtask

  task automatic send(input int pix, input bit sol, input bit eol, input int ph);
    int n   = 0;
    bit acc = 1'b0;
    if8.in_valid = 1'b1;
    if8.in_pixel = 8'(pix);
    if8.in_sol   = sol;
    if8.in_eol   = eol;
    if8.in_phase = 2'(ph);
    if8.in_tag   = 8'(tagc);
    while (!acc) begin
      @(negedge clock);
      acc = if8.in_ready;
      if (acc) begin
        last_acc_cyc = cyc;
        model_beat(pix, sol, eol, ph, tagc);
      end
      @(posedge clock);
      #1;
      n++;
      if (!acc && n > 100) begin
        fail("in_ready timeout");
        break;
      end
    end
    if8.in_valid = 1'b0;
    tagc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q10.size() != 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (n >= 200) fail("drain timeout");
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Downstream ready: steady 1, or toggling every cycle while bp_en is set.
  initial begin
    if8.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if8.out_ready = bp_en ? ~if8.out_ready : 1'b1;
    end
  end

  // 8-bit scoreboard plus stall-hold check.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_L && hold_v) begin
        chk("hold_valid", int'(if8.out_valid), 1);
        chk("hold_px", int'(if8.out_pixel), hold_px);
        chk("hold_tag", int'(if8.out_tag), hold_tag);
        chk("hold_eol", int'(if8.out_eol), hold_eol);
      end
      if (reset_L && if8.out_valid && if8.out_ready) begin
        if (q8.size() == 0) begin
          fail($sformatf("stray8 output px=%0d tag=%0d", if8.out_pixel, if8.out_tag));
        end else begin
          e8 = q8.pop_front();
          chk("px8", int'(if8.out_pixel), e8.px);
          chk("tag8", int'(if8.out_tag), e8.tag);
          chk("eol8", int'(if8.out_eol), e8.eol);
        end
        n8++;
        last8     = int'(if8.out_pixel);
        last_eol8 = int'(if8.out_eol);
        popcyc.push_back(cyc);
      end
      hold_v   = reset_L && if8.out_valid && !if8.out_ready;
      hold_px  = int'(if8.out_pixel);
      hold_tag = int'(if8.out_tag);
      hold_eol = int'(if8.out_eol);
    end
  end

  // 10-bit scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_L && if10.out_valid && if10.out_ready) begin
        if (q10.size() == 0) begin
          fail($sformatf("stray10 output px=%0d", if10.out_pixel));
        end else begin
          e10 = q10.pop_front();
          chk("px10", int'(if10.out_pixel), e10.px);
          chk("tag10", int'(if10.out_tag), e10.tag);
          chk("eol10", int'(if10.out_eol), e10.eol);
        end
        n10++;
        last10 = int'(if10.out_pixel);
      end
    end
  end

  initial begin
    int m, t8;
    tbl[0] = '{"imp_q1",   1, pk(0, 0, 0, 64, 0, 0, 0, 0), 58, 232};
    tbl[1] = '{"imp_q3",   3, pk(0, 0, 0, 64, 0, 0, 0, 0), 17, 68};
    tbl[2] = '{"imp_full", 0, pk(0, 0, 0, 64, 0, 0, 0, 0), 64, 256};
    tbl[3] = '{"clip_hi",  2, pk(0, 0, 0, 255, 255, 0, 0, 0), 255, 1023};
    tbl[4] = '{"clip_lo",  2, pk(255, 255, 255, 0, 0, 255, 255, 255), 0, 0};
    tbl[5] = '{"rnd_up",   1, pk(0, 0, 0, 0, 2, 0, 0, 0), 1, 2};
    tbl[6] = '{"rnd_dn",   1, pk(0, 0, 0, 0, 1, 0, 0, 0), 0, 1};
    tbl[7] = '{"flat_h",   2, pk(100, 100, 100, 100, 100, 100, 100, 100), 100, 400};
    for (int k = 0; k < 8; k++) mw[k] = 0;

    if8.in_valid = 1'b0;
    if8.in_pixel = '0;
    if8.in_sol   = 1'b0;
    if8.in_eol   = 1'b0;
    if8.in_phase = '0;
    if8.in_tag   = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst out_valid", int'(if8.out_valid), 0);
    chk("rst out_pixel", int'(if8.out_pixel), 0);
    chk("rst err", int'(if8.short_line_err), 0);
    chk("rst in_ready", int'(if8.in_ready), 1);
    reset_L = 1'b1;
    @(posedge clock);
    #1;

    // Flat lines: 16 beats of 100 per phase, 9 outputs, 3-cycle latency
    for (int ph = 0; ph < 4; ph++) begin
      m = n8;
      popcyc.delete();
      t8 = 0;
      for (int b = 0; b < 16; b++) begin
        send(100, b == 0, b == 15, ph);
        if (b == 7) t8 = last_acc_cyc;
      end
      drain();
      chk($sformatf("flat p%0d count", ph), n8 - m, 9);
      chk($sformatf("flat p%0d last", ph), last8, 100);
      if (popcyc.size() > 0) chk($sformatf("flat p%0d latency", ph), popcyc[0] - t8, 3);
      else fail($sformatf("flat p%0d latency: no output", ph));
    end

    // Table vectors: one 8-pixel line each
    for (int i = 0; i < 8; i++) begin
      m = n8;
      for (int k = 0; k < 8; k++) send(int'(tbl[i].px[8*k +: 8]), k == 0, k == 7, tbl[i].ph);
      drain();
      chk({tbl[i].name, " count"}, n8 - m, 1);
      chk({tbl[i].name, " bd8"}, last8, tbl[i].e8);
      chk({tbl[i].name, " bd10"}, last10, tbl[i].e10);
    end

    // sol at beat 10 restarts the window; 8th pixel of the new line is 7 beats later
    m = n8;
    for (int b = 0; b < 10; b++) send($urandom_range(0, 255), b == 0, 1'b0, 3);
    drain();
    chk("midsol first line", n8 - m, 3);
    m = n8;
    send($urandom_range(0, 255), 1'b1, 1'b0, 3);
    for (int b = 0; b < 6; b++) send($urandom_range(0, 255), 1'b0, 1'b0, 3);
    drain();
    chk("midsol before 8th", n8 - m, 0);
    send($urandom_range(0, 255), 1'b0, 1'b0, 3);
    drain();
    chk("midsol at 8th", n8 - m, 1);
    for (int b = 0; b < 4; b++) send($urandom_range(0, 255), 1'b0, b == 3, 3);
    drain();
    chk("midsol total", n8 - m, 5);
    chk("midsol eol", last_eol8, 1);
    chk("midsol err", int'(if8.short_line_err), 0);

    // Backpressure: 20-pixel line with out_ready toggling
    m = n8;
    bp_en = 1'b1;
    for (int b = 0; b < 20; b++) send($urandom_range(0, 255), b == 0, b == 19, 2);
    bp_en = 1'b0;
    drain();
    chk("bp count", n8 - m, 13);
    chk("bp last eol", last_eol8, 1);
    chk("bp count10", n10 - n8, 0);

    // Short line: 5 pixels then eol
    m = n8;
    for (int b = 0; b < 5; b++) send(77, b == 0, b == 4, 1);
    drain();
    chk("short count", n8 - m, 0);
    chk("short err8", int'(if8.short_line_err), 1);
    chk("short err10", int'(if10.short_line_err), 1);
    chk("short err model", int'(if8.short_line_err), merr);

    // Reset with two samples in flight
    for (int b = 0; b < 9; b++) send($urandom_range(1, 255), b == 0, 1'b0, 1);
    reset_L = 1'b0;
    #1;
    chk("mid rst out_valid", int'(if8.out_valid), 0);
    chk("mid rst out_pixel", int'(if8.out_pixel), 0);
    chk("mid rst out_tag", int'(if8.out_tag), 0);
    chk("mid rst out_eol", int'(if8.out_eol), 0);
    chk("mid rst err", int'(if8.short_line_err), 0);
    chk("mid rst out_pixel10", int'(if10.out_pixel), 0);
    q8.delete();
    q10.delete();
    mfill = 0;
    merr  = 0;
    m = n8;
    repeat (2) @(posedge clock);
    #1;
    reset_L = 1'b1;
    // Non-sol beats after reset are dropped
    for (int b = 0; b < 3; b++) send(200, 1'b0, 1'b0, 2);
    repeat (8) @(posedge clock);
    #1;
    chk("post rst stale", n8 - m, 0);
    for (int b = 0; b < 8; b++) send(50, b == 0, b == 7, 2);
    drain();
    chk("post rst count", n8 - m, 1);
    chk("post rst px", last8, 50);
    chk("post rst err", int'(if8.short_line_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/hevc_luma_interp_stream.md
Name: hevc_luma_interp_stream

Overview:
- Streaming, parametrised HEVC 8-tap luma sub-pixel interpolator.
- Accepts one integer pixel per beat, keeps an 8-pixel sliding window per line, and emits one interpolated sample per beat once the window is full.
- Supports runtime phase select: full-pel, 1/4, 1/2 and 3/4, using exact HEVC coefficients with rounding and two-sided clipping.
- Replaces the fixed-phase, truncating, single-cycle filters. Sits between the reference-pixel fetch and the prediction-block writer.

Parameters:
- BIT_DEPTH, 8, pixel width in bits; legal range 8..12.
- TAG_W, 8, width of the sideband tag carried alongside each pixel.

Ports:
- clock  in  1  single clock.
- reset_L  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_pixel  in  BIT_DEPTH  integer pixel, unsigned.
- in_sol  in  1  first pixel of a line.
- in_eol  in  1  last pixel of a line.
- in_phase  in  2  0 = full-pel, 1 = 1/4, 2 = 1/2, 3 = 3/4; sampled only on sol beats.
- in_tag  in  TAG_W  sideband tag, passed through.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_pixel  out  BIT_DEPTH  interpolated sample.
- out_tag  out  TAG_W  tag of the pixel that completed the window.
- out_eol  out  1  sample was produced by an eol beat.
- short_line_err  out  1  sticky: a line ended before 8 pixels.

Behaviour:
- Reset: asynchronous, active-low (reset_L). While asserted, every register clears: window, fill count, latched phase, pipeline valids, out_valid, out_pixel, out_tag, out_eol and short_line_err all go to 0. Reset mid-line discards all in-flight data; the first beat after reset must carry sol, and non-sol beats before that are accepted and dropped.
- Handshake and stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - All pipeline stages shift only on advance. out_* hold stable while out_valid && !out_ready.
- Window:
  - w[0..7], w[7] newest. An accepted beat shifts in_pixel into w[7].
  - fill_cnt counts 0..8 and saturates at 8.
  - An sol beat sets fill_cnt = 1 (window restarts, old contents are don't-care) and latches in_phase.
  - A beat produces an output iff fill_cnt after the update equals 8.
- Arithmetic (S2): sum = Σ c[p][k]·w[k], signed, BIT_DEPTH+8 bits.
  - p1 coefficients: -1, 4, -10, 58, 17, -5, 1, 0.
  - p2 coefficients: -1, 4, -11, 40, 40, -11, 4, -1.
  - p3 coefficients: 0, 1, -5, 17, 58, -10, 4, -1.
  - Implemented as shift-add only; no multipliers.
- Output (S3): res = (sum + 32) >>> 6, clipped to [0, 2^BIT_DEPTH − 1]. For p0, res = w[3] with no arithmetic.
- Pipeline and latency:
  - S1 = window + metadata, S2 = sum, S3 = output register.
  - An accepted beat in cycle t produces out_valid in cycle t+3 with no stall. Throughput is 1 sample per cycle.
- Line boundaries:
  - An eol beat with fill_cnt < 8 after update: no output, short_line_err set to 1, fill_cnt cleared.
  - An eol beat that completes or extends a full window: output with out_eol = 1, then fill_cnt cleared.
  - sol and eol on the same beat: a 1-pixel line, so short_line_err is set.
  - sol arriving mid-line: restarts the window; the previous line produces no eol output.
  - Non-sol beats while fill_cnt = 0 (after eol): accepted and dropped, no error.
  - in_phase changing on non-sol beats: ignored.

Decomposition:
- Package hevc_interp_pkg holds:
  - phase encodings: PH_FULL = 0, PH_Q1 = 1, PH_HALF = 2, PH_Q3 = 3;
  - the luma coefficient table;
  - FILTER_SHIFT = 6 and ROUND_OFS = 32;
  - a function for the sum width.
- One sub-module, hevc_luma_tap_sum: combinational shift-add of the 8-pixel window for a given phase, producing the signed sum. The top module owns the window, counters, handshake and clip.

Test Plan:
- Flat line: 16 beats of 100 for each phase 0..3 -> 9 outputs per line, all 100; the first output appears 3 cycles after the 8th accepted beat.
- Impulse: p1, window 0,0,0,64,0,0,0,0 -> 58. p3, same window -> 17. p0 -> 64.
- Clip: p2, window 0,0,0,255,255,0,0,0 -> 255 (raw 319). Window 255,255,255,0,0,255,255,255 -> 0 (sum −4080). BIT_DEPTH = 10 rerun of the same pattern scaled ×4 -> 1023 / 0.
- Rounding: p1, w[4] = 2 with all other pixels 0 -> 1. w[4] = 1 -> 0.
- Backpressure: out_ready toggled 1010... over a 20-pixel line -> no lost or duplicated samples; out_* held while stalled; 13 outputs; out_eol only on the last.
- Boundaries:
  - A 5-pixel line with eol -> no output, short_line_err = 1.
  - sol at beat 10 of a line -> window restarts; the next output appears 7 beats later.
  - reset_L pulsed with 2 samples in flight -> all outputs 0 immediately and no stale output afterwards.
